dest_scheduler: RTL and testbench
=================================

# dest_scheduler

Credit-based flow controller that feeds the two-way destination demux from a show-ahead source FIFO. Each cycle it inspects the head word's destination bit and checks a per-destination credit counter that mirrors free space in the downstream FIFO. When the word can be accepted, it pops the word and presents it with a one-hot valid to the demux. A small FSM provides RESET/INIT/IDLE/ACTIVE/ERROR sequencing and credit configuration.

## Interface
- BITNUMBER, 6, data word width; bit BITNUMBER-1 is the destination select (0 → out0, 1 → out1).
- CW, 3, credit counter width; maximum configurable credit is 2^CW-1.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- init  input  1  configuration request; credit limits load while high.
- credit_init0  input  CW  credit limit for destination 0, sampled in INIT.
- credit_init1  input  CW  credit limit for destination 1, sampled in INIT.
- fifo_empty  input  1  source FIFO empty.
- fifo_data  input  BITNUMBER  source FIFO head word; valid when fifo_empty=0 (show-ahead).
- credit_ret0  input  1  one-credit return pulse from downstream FIFO 0 (its pop).
- credit_ret1  input  1  one-credit return pulse from downstream FIFO 1.
- fifo_pop  output  1  source FIFO pop, combinational.
- data_out  output  BITNUMBER  registered word sent to the demux data input.
- valid_out0  output  1  registered; drives the demux valid for destination 0.
- valid_out1  output  1  registered; drives the demux valid for destination 1.
- state  output  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- idle_out  output  1  high while in IDLE.
- error_out  output  1  high while in ERROR.
- stall_count  output  16  head-of-line credit-stall counter (see Configuration).

## Operation
- FSM:
  - RESET: go to INIT next cycle.
  - INIT: while init=1, load limit0/1 and credit0/1 from credit_init0/1 every cycle. On init=0, go to IDLE.
  - IDLE: if fifo_empty=0, go to ACTIVE.
  - ACTIVE: if fifo_empty=1, go to IDLE.
  - From IDLE or ACTIVE, init=1 goes to INIT.
  - Any error condition goes to ERROR. ERROR is sticky and exits only on reset.
- Issue rule (ACTIVE only): with d = fifo_data[BITNUMBER-1], fifo_pop = !fifo_empty && credit_d != 0. No pop occurs in any other state.
- On a pop, the next edge registers data_out = fifo_data, sets valid_out_d=1 and the other valid to 0, and decrements credit_d.
- Without a pop, data_out=0 and valid_out0=valid_out1=0. valid_out0 and valid_out1 are never high together.
- Credit update per destination per cycle:
  - Pop only: -1.
  - Return only: +1.
  - Pop and return together: unchanged.
- Credit returns are accepted in IDLE and ACTIVE. Returns in INIT are ignored.
- Error conditions:
  - A return with no same-cycle pop to that destination while credit_d == limit_d (credit overflow).
  - fifo_pop would occur with fifo_empty=1. This cannot happen by construction, but the check is present as a guard.
- Head-of-line blocking: a head word with no credit stalls the whole queue, even if the other destination has credit. The scheduler does not reorder.
- A limit of 0 permanently blocks that destination. This is legal, not an error.

## Timing
- Reset values: data_out=0, valid_out0=0, valid_out1=0, state=RESET, idle_out=0, error_out=0, stall_count=0, credit0/1=0, limit0/1=0. fifo_pop is 0 because state≠ACTIVE.
- Latency: fifo_pop at cycle t → data_out/valid_out at t+1 → demux outputs at t+2.
- Throughput: one word per cycle while the head destination has credit.
- The FSM needs ACTIVE for a pop. Data arriving into an empty FIFO at cycle t moves IDLE→ACTIVE at edge t, so the first pop is in cycle t+1.
- ACTIVE→IDLE is taken the cycle fifo_empty=1 is seen. A pop in the same cycle is impossible.
- Credit reaching 0 on a pop blocks that destination the following cycle. A same-cycle return prevents the block.
- Reset asserted mid-transfer: all registers clear immediately and asynchronously. In-flight valid_out pulses are dropped. The source FIFO is reset by its own owner.
- Entering INIT from ACTIVE discards outstanding-credit accounting: counters are reloaded to the new limits.

## Configuration
- DEST_SCHED_STATS_EN defined:
  - stall_count increments once per cycle in ACTIVE where fifo_empty=0 and credit_d==0.
  - It saturates at 16'hFFFF and clears on reset or in INIT.
- DEST_SCHED_STATS_EN undefined: stall_count is tied to 0 and no counter logic is built.
- The port list is identical in both builds.

## Test plan
- Reset, init=1 with credit_init0=2, credit_init1=3, release, 3 words to dest0 queued, no returns → pops at two consecutive cycles; valid_out0 pulses twice with matching data; then fifo_pop=0 and the third word stalls.
- From that stall, pulse credit_ret0 once → exactly one further pop, valid_out0 one cycle later, credit0 back to 0.
- Alternating dest bits 0/1/0/1 with ample credit → one pop per cycle; one-hot valid_out0/valid_out1 alternate; data_out matches the FIFO order.
- credit_ret1 pulse while credit1==limit1 with no pop → state=4, error_out=1, fifo_pop=0; state holds until reset is asserted.
- Simultaneous pop and credit_ret0 on dest0 with credit0=1 → credit0 stays 1 and the next dest0 word pops the following cycle.
- With DEST_SCHED_STATS_EN: dest1 limit 0, head word dest1 held 10 cycles in ACTIVE → stall_count=10. Without the macro: stall_count=0.

Source files
------------

// File: rtl/dest_scheduler_if.sv
// ---------------------------------------------------------------------------
// dest_scheduler_if
// Bundles the data-path signals that run between the source FIFO, the
// destination scheduler and the two-way destination demux.
//
// Signals:
//   fifo_empty   source FIFO empty flag
//   fifo_data    source FIFO head word (show-ahead, valid when !fifo_empty)
//   fifo_pop     pop strobe back to the source FIFO
//   data_out     registered word presented to the demux
//   valid_out0   registered one-hot valid for destination 0
//   valid_out1   registered one-hot valid for destination 1
//   credit_ret0  one-credit return pulse from downstream FIFO 0
//   credit_ret1  one-credit return pulse from downstream FIFO 1
//
// Modports:
//   master  the scheduler side (consumes FIFO/credit status, drives pop/data)
//   slave   the environment side (FIFO, demux and downstream credit source)
// ---------------------------------------------------------------------------
interface dest_scheduler_if #(
  parameter int BITNUMBER = 6
);
  logic                 fifo_empty;
  logic [BITNUMBER-1:0] fifo_data;
  logic                 fifo_pop;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid_out0;
  logic                 valid_out1;
  logic                 credit_ret0;
  logic                 credit_ret1;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  credit_ret0,
    input  credit_ret1,
    output fifo_pop,
    output data_out,
    output valid_out0,
    output valid_out1
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output credit_ret0,
    output credit_ret1,
    input  fifo_pop,
    input  data_out,
    input  valid_out0,
    input  valid_out1
  );
endinterface

// File: rtl/dest_scheduler.sv
// ---------------------------------------------------------------------------
// dest_scheduler
// Credit-based flow controller between a show-ahead source FIFO and a two-way
// destination demux. The MSB of the head word selects the destination; a word
// is popped only while the scheduler is ACTIVE and that destination still has
// credit. Credits mirror free space in each downstream FIFO and are returned
// one at a time by credit_ret0/1. The scheduler never reorders: a head word
// without credit stalls the whole queue.
//
// Optional feature macro: DEST_SCHED_STATS_EN
//   defined   -> stall_count counts ACTIVE cycles lost to a credit stall
//                (saturating, cleared in INIT)
//   undefined -> stall_count is tied to zero, no counter is built
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   init          configuration request; limits/credits load while high in INIT
//   credit_init0  credit limit for destination 0
//   credit_init1  credit limit for destination 1
//   bus           dest_scheduler_if.master (FIFO, demux and credit-return signals)
//   state         FSM state: RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle_out      high while in IDLE
//   error_out     high while in ERROR (sticky until reset)
//   stall_count   head-of-line credit-stall counter
// ---------------------------------------------------------------------------
module dest_scheduler #(
  parameter int BITNUMBER = 6,
  parameter int CW        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CW-1:0]        credit_init0,
  input  logic [CW-1:0]        credit_init1,
  dest_scheduler_if.master     bus,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 error_out,
  output logic [15:0]          stall_count
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [CW-1:0] CREDIT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   credit0;
  logic [CW-1:0]   credit1;
  logic [CW-1:0]   limit0;
  logic [CW-1:0]   limit1;
  logic            dest_sel;
  logic            head_has_credit;
  logic            pop;
  logic            pop0;
  logic            pop1;
  logic            ret_window;
  logic            ret0;
  logic            ret1;
  logic            overflow;
  logic            pop_when_empty;
  logic            err;

  // Net credit change for one destination: a pop and a return in the same
  // cycle cancel out.
  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] cur,
                                                input logic          popped,
                                                input logic          returned);
    logic [CW-1:0] res;
    res = cur;
    if (popped && !returned)
      res = cur - CREDIT_ONE;
    else if (returned && !popped)
      res = cur + CREDIT_ONE;
    return res;
  endfunction

  assign dest_sel        = bus.fifo_data[BITNUMBER-1];
  assign head_has_credit = dest_sel ? (credit1 != '0) : (credit0 != '0);

  // The pop is combinational so a word can leave the FIFO every cycle.
  assign pop  = (state_q == ST_ACTIVE) && !bus.fifo_empty && head_has_credit;
  assign pop0 = pop && !dest_sel;
  assign pop1 = pop &&  dest_sel;

  // Returns only count while the credit accounting is live; in INIT the
  // counters are being reloaded and stray returns are dropped.
  assign ret_window = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign ret0       = ret_window && bus.credit_ret0;
  assign ret1       = ret_window && bus.credit_ret1;

  // A return that would push a counter above its limit means the downstream
  // side and the scheduler disagree about occupancy.
  assign overflow       = (ret0 && !pop0 && (credit0 == limit0)) ||
                          (ret1 && !pop1 && (credit1 == limit1));
  assign pop_when_empty = pop && bus.fifo_empty;
  assign err            = overflow || pop_when_empty;

  assign bus.fifo_pop = pop;
  assign state        = state_q;

  // Next-state selection; errors win over a configuration request, which in
  // turn wins over the empty/non-empty transitions. Unused encodings fall
  // into ERROR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (err)                  state_d = ST_ERROR;
        else if (init)            state_d = ST_INIT;
        else if (!bus.fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err)                 state_d = ST_ERROR;
        else if (init)           state_d = ST_INIT;
        else if (bus.fifo_empty) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  // State register, registered status flags, demux outputs and credit
  // bookkeeping. Credits freeze once an error is detected so the counters
  // keep the values that led to the fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RESET;
      idle_out       <= 1'b0;
      error_out      <= 1'b0;
      bus.data_out   <= '0;
      bus.valid_out0 <= 1'b0;
      bus.valid_out1 <= 1'b0;
      credit0        <= '0;
      credit1        <= '0;
      limit0         <= '0;
      limit1         <= '0;
    end else begin
      state_q        <= state_d;
      idle_out       <= (state_d == ST_IDLE);
      error_out      <= (state_d == ST_ERROR);
      bus.data_out   <= pop ? bus.fifo_data : '0;
      bus.valid_out0 <= pop0;
      bus.valid_out1 <= pop1;
      if ((state_q == ST_INIT) && init) begin
        limit0  <= credit_init0;
        limit1  <= credit_init1;
        credit0 <= credit_init0;
        credit1 <= credit_init1;
      end else if (ret_window && !err) begin
        credit0 <= next_credit(credit0, pop0, ret0);
        credit1 <= next_credit(credit1, pop1, ret1);
      end
    end
  end

`ifdef DEST_SCHED_STATS_EN
  logic [15:0] stall_q;
  logic        stall_now;

  assign stall_now   = (state_q == ST_ACTIVE) && !bus.fifo_empty && !head_has_credit;
  assign stall_count = stall_q;

  // Saturating stall counter; restarts whenever the scheduler is reconfigured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_q <= 16'd0;
    else if (state_q == ST_INIT)
      stall_q <= 16'd0;
    else if (stall_now && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_dest_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dest_scheduler
// Directed self-checking bench for dest_scheduler. A small show-ahead FIFO
// model feeds the scheduler; each scenario task drives its own vectors and
// compares the outputs against hand-computed values one cycle at a time.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_dest_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [2:0]  credit_init0;
  logic [2:0]  credit_init1;
  logic [2:0]  state;
  logic        idle_out;
  logic        error_out;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  dest_scheduler_if #(.BITNUMBER(6)) bus ();

  dest_scheduler #(.BITNUMBER(6), .CW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .credit_init0 (credit_init0),
    .credit_init1 (credit_init1),
    .bus          (bus),
    .state        (state),
    .idle_out     (idle_out),
    .error_out    (error_out),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // Show-ahead source FIFO model: the head word is always visible and
  // advances on the edge that sees fifo_pop.
  logic [5:0] fifo_mem [0:15];
  int         rd_ptr = 0;
  int         wr_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_data  = fifo_mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (bus.fifo_pop) rd_ptr <= rd_ptr + 1;
  end

  initial begin
    for (int i = 0; i < 16; i++) fifo_mem[i] = 6'h00;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [5:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; credit_init0 = 3'd0; credit_init1 = 3'd0;
    bus.credit_ret0 = 1'b0; bus.credit_ret1 = 1'b0;
    cyc(); cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (bus.data_out !== 6'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", bus.data_out); end
    checks++; if ({bus.valid_out0, bus.valid_out1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 00", {bus.valid_out0, bus.valid_out1}); end
    checks++; if ({idle_out, error_out} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {idle_out, error_out}); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_count); end
    checks++; if (bus.fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop: got %b expected 0", bus.fifo_pop); end
    reset = 1'b1;
    cyc();
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL reset_to_init: got %0d expected 1", state); end
  endtask

  // Limits 2/3, three dest0 words: two pops, then the third word stalls.
  task automatic test_credit_stall();
    init = 1'b1; credit_init0 = 3'd2; credit_init1 = 3'd3;
    cyc();
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL cfg_hold_init: got %0d expected 1", state); end
    init = 1'b0;
    cyc();
    checks++; if (state !== 3'd2 || idle_out !== 1'b1) begin errors++; $display("[TB] FAIL cfg_to_idle: got state %0d idle %b expected 2 1", state, idle_out); end
    push_word(6'h05); push_word(6'h0A); push_word(6'h13);
    cyc();
    checks++; if (state !== 3'd3 || bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL stall_first_pop: got state %0d pop %b expected 3 1", state, bus.fifo_pop); end
    cyc();
    checks++; if (bus.data_out !== 6'h05 || bus.valid_out0 !== 1'b1 || bus.valid_out1 !== 1'b0) begin errors++; $display("[TB] FAIL stall_word0: got %h v0 %b v1 %b expected 05 1 0", bus.data_out, bus.valid_out0, bus.valid_out1); end
    checks++; if (bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL stall_second_pop: got %b expected 1", bus.fifo_pop); end
    cyc();
    checks++; if (bus.data_out !== 6'h0A || bus.valid_out0 !== 1'b1) begin errors++; $display("[TB] FAIL stall_word1: got %h v0 %b expected 0A 1", bus.data_out, bus.valid_out0); end
    checks++; if (bus.fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL stall_blocked: got %b expected 0", bus.fifo_pop); end
    cyc();
    checks++; if (bus.valid_out0 !== 1'b0 || bus.data_out !== 6'h00 || bus.fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold: got v0 %b data %h pop %b expected 0 00 0", bus.valid_out0, bus.data_out, bus.fifo_pop); end
  endtask

  // One returned credit releases exactly one stalled word.
  task automatic test_credit_return();
    bus.credit_ret0 = 1'b1;
    cyc();
    bus.credit_ret0 = 1'b0;
    checks++; if (bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL ret_pop: got %b expected 1", bus.fifo_pop); end
    cyc();
    checks++; if (bus.data_out !== 6'h13 || bus.valid_out0 !== 1'b1) begin errors++; $display("[TB] FAIL ret_word: got %h v0 %b expected 13 1", bus.data_out, bus.valid_out0); end
    cyc();
    checks++; if (state !== 3'd2 || bus.valid_out0 !== 1'b0) begin errors++; $display("[TB] FAIL ret_to_idle: got state %0d v0 %b expected 2 0", state, bus.valid_out0); end
    push_word(6'h07);
    cyc();
    checks++; if (state !== 3'd3 || bus.fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL ret_credit_zero: got state %0d pop %b expected 3 0", state, bus.fifo_pop); end
  endtask

  // Alternating destinations with plenty of credit: one word per cycle.
  task automatic test_alternating();
    logic [5:0] exp_words [4];
    logic [5:0] e;
    exp_words = '{6'h01, 6'h22, 6'h03, 6'h24};
    init = 1'b1; credit_init0 = 3'd7; credit_init1 = 3'd7;
    flush_fifo();
    cyc();
    checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL alt_to_init: got %0d expected 1", state); end
    cyc();
    init = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) push_word(exp_words[i]);
    cyc();
    checks++; if (state !== 3'd3 || bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL alt_start: got state %0d pop %b expected 3 1", state, bus.fifo_pop); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      e = exp_words[i];
      checks++;
      if (bus.data_out !== e || bus.valid_out0 !== ~e[5] || bus.valid_out1 !== e[5]) begin
        errors++;
        $display("[TB] FAIL alt_word%0d: got %h v0 %b v1 %b expected %h %b %b", i, bus.data_out, bus.valid_out0, bus.valid_out1, e, ~e[5], e[5]);
      end
    end
    cyc();
    checks++; if (state !== 3'd2 || {bus.valid_out0, bus.valid_out1} !== 2'b00) begin errors++; $display("[TB] FAIL alt_end: got state %0d valids %b expected 2 00", state, {bus.valid_out0, bus.valid_out1}); end
  endtask

  // Pop and return on dest0 in the same cycle with credit0=1 keeps it at 1.
  task automatic test_simultaneous();
    init = 1'b1; credit_init0 = 3'd1; credit_init1 = 3'd3;
    cyc(); cyc();
    init = 1'b0;
    cyc();
    push_word(6'h11); push_word(6'h12);
    cyc();
    checks++; if (bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL sim_first_pop: got %b expected 1", bus.fifo_pop); end
    bus.credit_ret0 = 1'b1;
    cyc();
    bus.credit_ret0 = 1'b0;
    checks++; if (bus.data_out !== 6'h11 || bus.valid_out0 !== 1'b1 || state !== 3'd3) begin errors++; $display("[TB] FAIL sim_word0: got %h v0 %b state %0d expected 11 1 3", bus.data_out, bus.valid_out0, state); end
    checks++; if (bus.fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL sim_second_pop: got %b expected 1", bus.fifo_pop); end
    cyc();
    checks++; if (bus.data_out !== 6'h12 || bus.valid_out0 !== 1'b1) begin errors++; $display("[TB] FAIL sim_word1: got %h v0 %b expected 12 1", bus.data_out, bus.valid_out0); end
    cyc();
  endtask

  // Return on dest1 while credit1 == limit1 and no pop: sticky ERROR.
  task automatic test_error();
    checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL err_pre_idle: got %0d expected 2", state); end
    bus.credit_ret1 = 1'b1;
    cyc();
    bus.credit_ret1 = 1'b0;
    checks++; if (state !== 3'd4 || error_out !== 1'b1 || idle_out !== 1'b0) begin errors++; $display("[TB] FAIL err_enter: got state %0d err %b idle %b expected 4 1 0", state, error_out, idle_out); end
    push_word(6'h2F);
    cyc(); cyc(); cyc();
    checks++; if (state !== 3'd4 || bus.fifo_pop !== 1'b0 || bus.valid_out1 !== 1'b0) begin errors++; $display("[TB] FAIL err_sticky: got state %0d pop %b v1 %b expected 4 0 0", state, bus.fifo_pop, bus.valid_out1); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || error_out !== 1'b0) begin errors++; $display("[TB] FAIL err_async_reset: got state %0d err %b expected 0 0", state, error_out); end
    cyc();
    flush_fifo();
    reset = 1'b1;
  endtask

  // Dest1 limit 0 holds a dest1 head word; the dest0 word behind it waits.
  task automatic test_stall_count();
    int exp_stall;
`ifdef DEST_SCHED_STATS_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif
    init = 1'b1; credit_init0 = 3'd2; credit_init1 = 3'd0;
    cyc(); cyc();
    init = 1'b0;
    cyc();
    push_word(6'h30); push_word(6'h01);
    cyc();
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (stall_count !== exp_stall[15:0]) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", stall_count, exp_stall); end
    checks++; if (state !== 3'd3 || bus.fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL hol_block: got state %0d pop %b expected 3 0", state, bus.fifo_pop); end
    init = 1'b1;
    flush_fifo();
    cyc(); cyc();
    checks++; if (state !== 3'd1 || stall_count !== 16'd0) begin errors++; $display("[TB] FAIL stall_clear: got state %0d count %0d expected 1 0", state, stall_count); end
    init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_credit_stall();
    test_credit_return();
    test_alternating();
    test_simultaneous();
    test_error();
    test_stall_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
